// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder.
// Folds E0/F0 prefixes into single key events, drops housekeeping bytes and
// the Pause sequence, tracks eight game-control keys, and queues events in a
// first-word-fall-through FIFO with a valid/ready handshake.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       overflow,
    output logic [7:0] key_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX_E0,
        S_PFX_F0,
        S_PFX_E0F0,
        S_SKIP
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_cnt_q, skip_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]    key_state_q, key_state_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [9:0]    fifo_mem_q [FIFO_DEPTH];

    logic          emit, emit_ext, emit_brk;
    logic          fifo_empty, fifo_full, pop, push_ok;
    logic [9:0]    head;
    logic [3:0]    key_hit;

    // Maps an event to {tracked, bit index}; ext must match exactly.
    function automatic logic [3:0] key_index(input logic [7:0] code, input logic ext);
        case ({ext, code})
            9'h01D:  key_index = 4'b1_000;
            9'h01C:  key_index = 4'b1_001;
            9'h01B:  key_index = 4'b1_010;
            9'h023:  key_index = 4'b1_011;
            9'h175:  key_index = 4'b1_100;
            9'h172:  key_index = 4'b1_101;
            9'h16B:  key_index = 4'b1_110;
            9'h174:  key_index = 4'b1_111;
            default: key_index = 4'b0_000;
        endcase
    endfunction

    // Prefix/skip state machine with idle timeout; decides when an event is emitted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        tmo_cnt_d  = (state_q == S_IDLE) ? '0 : tmo_cnt_q + 1'b1;

        if (byte_valid) begin
            tmo_cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    case (byte_in)
                        8'hE0: state_d = S_PFX_E0;
                        8'hF0: state_d = S_PFX_F0;
                        8'hE1: begin
                            state_d    = S_SKIP;
                            skip_cnt_d = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                        default: emit = 1'b1;
                    endcase
                end
                S_PFX_E0: begin
                    if (byte_in == 8'hF0) begin
                        state_d = S_PFX_E0F0;
                    end else begin
                        state_d  = S_IDLE;
                        emit     = (byte_in != 8'h12) && (byte_in != 8'h59);
                        emit_ext = 1'b1;
                    end
                end
                S_PFX_F0: begin
                    state_d  = S_IDLE;
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                end
                S_PFX_E0F0: begin
                    state_d  = S_IDLE;
                    emit     = (byte_in != 8'h12) && (byte_in != 8'h59);
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
                S_SKIP: begin
                    skip_cnt_d = skip_cnt_q - 3'd1;
                    if (skip_cnt_q == 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = S_IDLE;
            skip_cnt_d = '0;
            tmo_cnt_d  = '0;
        end
    end

    // Held-key bitmap and FIFO pointer/overflow bookkeeping.
    always_comb begin
        key_hit     = key_index(byte_in, emit_ext);
        key_state_d = key_state_q;
        if (emit && key_hit[3]) key_state_d[key_hit[2:0]] = ~emit_brk;

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = ~fifo_empty & evt_ready;
        push_ok    = emit & (~fifo_full | pop);
        overflow_d = overflow_q | (emit & fifo_full & ~pop);
        wr_ptr_d   = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d   = rd_ptr_q + (AW + 1)'(pop);
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            skip_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            key_state_q <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            key_state_q <= key_state_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Event storage; write gated by push_ok.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are live.
        if (push_ok && !reset) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {emit_brk, emit_ext, byte_in};
    end

    assign head      = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign evt_valid = ~fifo_empty;
    assign evt_code  = fifo_empty ? 8'h00 : head[7:0];
    assign evt_ext   = ~fifo_empty & head[8];
    assign evt_break = ~fifo_empty & head[9];
    assign overflow  = overflow_q;
    assign key_state = key_state_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext, evt_break, evt_valid, overflow;
    logic [7:0] key_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .key_state (key_state)
    );

    always #5 clk = ~clk;

    // {valid, code, ext, brk} of the head event
    function automatic logic [10:0] head_of();
        return {evt_valid, evt_code, evt_ext, evt_break};
    endfunction

    function automatic logic [10:0] ev(input logic [7:0] code, input logic ext, input logic brk);
        return {1'b1, code, ext, brk};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset      = 1'b1;
        byte_in    = 8'h1D;
        byte_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (head_of() !== 11'h0) $display("FAIL reset_head got %h exp %h", head_of(), 11'h0);
        else pass_cnt++;
        total_cnt++;
        if ({overflow, key_state} !== 9'h0) $display("FAIL reset_flags got %h exp %h", {overflow, key_state}, 9'h0);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (evt_valid !== 1'b0) $display("FAIL reset_ignore_byte got %b exp 0", evt_valid);
        else pass_cnt++;
    endtask

    task automatic test_make_break();
        evt_ready = 1'b1;
        send_byte(8'h1D);
        total_cnt++;
        if (head_of() !== ev(8'h1D, 0, 0)) $display("FAIL w_make got %h exp %h", head_of(), ev(8'h1D, 0, 0));
        else pass_cnt++;
        total_cnt++;
        if (key_state !== 8'h01) $display("FAIL w_make_ks got %h exp 01", key_state);
        else pass_cnt++;
        send_byte(8'hF0);
        send_byte(8'h1D);
        total_cnt++;
        if (head_of() !== ev(8'h1D, 0, 1)) $display("FAIL w_break got %h exp %h", head_of(), ev(8'h1D, 0, 1));
        else pass_cnt++;
        total_cnt++;
        if (key_state !== 8'h00) $display("FAIL w_break_ks got %h exp 00", key_state);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (evt_valid !== 1'b0) $display("FAIL w_drained got %b exp 0", evt_valid);
        else pass_cnt++;
        evt_ready = 1'b0;
    endtask

    task automatic test_ext_keys();
        evt_ready = 1'b1;
        send_byte(8'hE0); send_byte(8'h75);
        total_cnt++;
        if (head_of() !== ev(8'h75, 1, 0) || key_state !== 8'h10)
            $display("FAIL up_make got %h/%h exp %h/10", head_of(), key_state, ev(8'h75, 1, 0));
        else pass_cnt++;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        total_cnt++;
        if (head_of() !== ev(8'h75, 1, 1) || key_state !== 8'h00)
            $display("FAIL up_break got %h/%h exp %h/00", head_of(), key_state, ev(8'h75, 1, 1));
        else pass_cnt++;
        send_byte(8'h75);
        total_cnt++;
        if (head_of() !== ev(8'h75, 0, 0) || key_state !== 8'h00)
            $display("FAIL kp8_make got %h/%h exp %h/00", head_of(), key_state, ev(8'h75, 0, 0));
        else pass_cnt++;
        @(posedge clk); #1;
        evt_ready = 1'b0;
    endtask

    task automatic test_discard();
        send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h7C);
        send_byte(8'hAA); send_byte(8'hFA);
        total_cnt++;
        if (head_of() !== ev(8'h7C, 1, 0)) $display("FAIL prtsc got %h exp %h", head_of(), ev(8'h7C, 1, 0));
        else pass_cnt++;
        pop_one();
        total_cnt++;
        if (evt_valid !== 1'b0 || key_state !== 8'h00)
            $display("FAIL prtsc_only got %b/%h exp 0/00", evt_valid, key_state);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        logic [7:0] seq [9];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        for (int i = 0; i < 9; i++) send_byte(seq[i]);
        total_cnt++;
        if (head_of() !== ev(8'h1C, 0, 0) || key_state !== 8'h02)
            $display("FAIL pause_then_a got %h/%h exp %h/02", head_of(), key_state, ev(8'h1C, 0, 0));
        else pass_cnt++;
        pop_one();
        total_cnt++;
        if (evt_valid !== 1'b0) $display("FAIL pause_single got %b exp 0", evt_valid);
        else pass_cnt++;
        send_byte(8'hF0); send_byte(8'h1C);
        total_cnt++;
        if (head_of() !== ev(8'h1C, 0, 1) || key_state !== 8'h00)
            $display("FAIL a_break got %h/%h exp %h/00", head_of(), key_state, ev(8'h1C, 0, 1));
        else pass_cnt++;
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_codes [4];
        exp_codes = '{8'h1C, 8'h1B, 8'h23, 8'h34};
        send_byte(8'h1D); send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h23);
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL full_no_ovf got %b exp 0", overflow);
        else pass_cnt++;
        send_byte(8'h2B);
        total_cnt++;
        if (overflow !== 1'b1 || key_state !== 8'h0F || head_of() !== ev(8'h1D, 0, 0))
            $display("FAIL ovf_drop got %b/%h/%h exp 1/0F/%h", overflow, key_state, head_of(), ev(8'h1D, 0, 0));
        else pass_cnt++;
        // push and pop in the same cycle while full
        @(posedge clk); #1;
        byte_in    = 8'h34;
        byte_valid = 1'b1;
        evt_ready  = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        evt_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (head_of() !== ev(exp_codes[i], 0, 0))
                $display("FAIL drain_%0d got %h exp %h", i, head_of(), ev(exp_codes[i], 0, 0));
            else pass_cnt++;
            pop_one();
        end
        total_cnt++;
        if (evt_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL drain_end got %b/%b exp 0/1", evt_valid, overflow);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL ovf_cleared got %b exp 0", overflow);
        else pass_cnt++;
        // byte arrives on the last cycle before the timeout fires: prefix kept
        send_byte(8'hE0);
        repeat (TMO - 2) @(posedge clk);
        send_byte(8'h75);
        total_cnt++;
        if (head_of() !== ev(8'h75, 1, 0) || key_state !== 8'h10)
            $display("FAIL tmo_edge got %h/%h exp %h/10", head_of(), key_state, ev(8'h75, 1, 0));
        else pass_cnt++;
        pop_one();
        // full timeout elapses: prefix abandoned
        send_byte(8'hE0);
        repeat (TMO - 1) @(posedge clk);
        send_byte(8'h75);
        total_cnt++;
        if (head_of() !== ev(8'h75, 0, 0) || key_state !== 8'h10)
            $display("FAIL tmo_expired got %h/%h exp %h/10", head_of(), key_state, ev(8'h75, 0, 0));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        send_byte(8'h1D);
        send_byte(8'hF0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total_cnt++;
        if (head_of() !== 11'h0 || overflow !== 1'b0 || key_state !== 8'h00)
            $display("FAIL mid_reset got %h/%b/%h exp 000/0/00", head_of(), overflow, key_state);
        else pass_cnt++;
        send_byte(8'h1D);
        total_cnt++;
        if (head_of() !== ev(8'h1D, 0, 0) || key_state !== 8'h01)
            $display("FAIL post_reset_make got %h/%h exp %h/01", head_of(), key_state, ev(8'h1D, 0, 0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_ext_keys();
        test_discard();
        test_pause();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits between ps2_keyboard_controller (raw Set-2 scan bytes with a one-cycle ready strobe) and the game logic on the clk_100 domain.
- Folds the E0 (extended) and F0 (break) prefixes into single key events, discards keyboard housekeeping bytes and the Pause sequence, and buffers events in a small first-word-fall-through FIFO with a valid/ready handshake.
- Maintains a live held-key bitmap for the eight game-control keys.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 200000, idle clk cycles after which a partial prefix or skip sequence is abandoned (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock (clk_100 domain).
- reset  in  1  synchronous, active-high reset.
- byte_in  in  8  scan byte from the PS/2 controller; sampled only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe marking a new byte.
- evt_code  out  8  key code of the head event (prefix bytes removed).
- evt_ext  out  1  head event was E0-prefixed.
- evt_break  out  1  head event is a release (F0-prefixed).
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head event when evt_valid=1 and evt_ready=1.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- key_state  out  8  held keys: [0]W 1D, [1]A 1C, [2]S 1B, [3]D 23, [4]Up E0 75, [5]Down E0 72, [6]Left E0 6B, [7]Right E0 74.

Behaviour:
- Reset (sync, active-high, takes priority over everything): FSM=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, overflow=0, key_state=0, timeout and skip counters=0.
- byte_valid is ignored during reset.

FSM states: IDLE, PFX_E0, PFX_F0, PFX_E0F0, SKIP.
- IDLE:
  - E0 -> PFX_E0; F0 -> PFX_F0.
  - E1 -> SKIP with skip_cnt=7.
  - 00, AA, EE, FA, FE, FF are discarded; stay IDLE.
  - Any other byte emits a make event {code, ext=0, brk=0}.
- PFX_E0:
  - F0 -> PFX_E0F0.
  - 12 or 59 (fake shift) is discarded -> IDLE.
  - Any other byte emits {code, ext=1, brk=0} -> IDLE.
- PFX_F0: any byte emits {code, ext=0, brk=1} -> IDLE.
- PFX_E0F0:
  - 12 or 59 is discarded -> IDLE.
  - Any other byte emits {code, ext=1, brk=1} -> IDLE.
- SKIP: each byte decrements skip_cnt; when the byte that brings skip_cnt to 0 arrives -> IDLE. No events and no key_state change.

Timeout:
- The counter clears on every byte_valid.
- In any non-IDLE state, reaching TIMEOUT_CYCLES-1 without a byte forces IDLE. No event is emitted.

Emit timing:
- An emit happens in the cycle byte_valid is sampled (cycle N).
- The FIFO write and the key_state update are registered and visible at N+1.
- From an empty FIFO, evt_valid=1 at N+1 (latency 1).

key_state:
- A make event for a tracked key sets its bit; the matching break clears it. ext must match the table exactly (e.g. code 75 without E0 does not touch Up).
- key_state updates even when the event is dropped for overflow.

FIFO:
- First-word-fall-through: evt_code, evt_ext and evt_break show the head whenever evt_valid=1 and hold stable until popped.
- Pop when evt_valid and evt_ready. Push on emit.
- Push while full and no pop in the same cycle: the new event is dropped, overflow is set, and it stays set until reset.
- Push and pop in the same cycle while full: both succeed, occupancy is unchanged, no overflow.
- Push and pop in the same cycle while empty: not possible, since the new entry is not visible until N+1.
- Pointers wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.
- evt_ready while empty has no effect.
- Input bytes never stall; there is no back-pressure to the PS/2 side.

Test Plan:
- Reset, then bytes 1D, F0 1D with evt_ready=1 -> events {1D,ext0,brk0} then {1D,ext0,brk1}; key_state[0] goes 1 then 0; evt_valid is high one cycle after each final byte.
- Bytes E0 75, E0 F0 75, then plain 75 -> key_state[4] goes 1 then 0; the third event is {75,ext0,brk0} and key_state[4] stays 0.
- Bytes E0 12 E0 7C (PrintScreen make) and AA, FA -> one event {7C,ext1,brk0} only.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C -> exactly one event {1C,0,0}; key_state[1]=1.
- evt_ready=0, 5 make codes with FIFO_DEPTH=4 -> four events retained in order, the fifth dropped, overflow=1. Then evt_ready=1 and a new byte arriving in the same cycle as a pop while full -> no further drop. overflow stays 1 until reset.
- Byte E0, then TIMEOUT_CYCLES idle cycles, then 75 -> event {75,ext0,brk0}. Separately, F0 followed by reset asserted mid-sequence -> all outputs return to reset values and the next 1D produces a make event.
